// File: rtl/lift_pkg.sv
// Shared types and helpers for the 3-floor lift scheduler.
// Floors are numbered 1..NFLOORS; index 0 means "no floor".
package lift_pkg;

  localparam int NFLOORS = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    TRAVEL,
    DOOR,
    FAULT
  } state_t;

  function automatic logic [NFLOORS-1:0] floor_to_onehot(input logic [1:0] floor);
    logic [NFLOORS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (floor == 2'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Zero or multi-hot input maps to 0 so callers can treat it as invalid.
  function automatic logic [1:0] onehot_to_floor(input logic [NFLOORS-1:0] oh);
    case (oh)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lift_next_floor.sv
// Combinational SCAN selector: nearest pending floor in the current
// direction first, otherwise the nearest one in the opposite direction.
module lift_next_floor
  import lift_pkg::*;
(
  input  logic [NFLOORS-1:0] pending,
  input  logic [1:0]         cur_floor,
  input  logic               dir_up,
  output logic [1:0]         target,
  output logic               valid,
  output logic               new_dir
);

  logic [1:0] w_up;
  logic [1:0] w_dn;

  // Downward scan leaves the lowest floor above; upward scan the highest below.
  always_comb begin
    w_up = '0;
    w_dn = '0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i + 1) > int'(cur_floor)) w_up = 2'(i + 1);
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending[i] && (i + 1) < int'(cur_floor)) w_dn = 2'(i + 1);
    end
  end

  assign valid   = (w_up != 2'd0) || (w_dn != 2'd0);
  assign target  = dir_up ? ((w_up != 2'd0) ? w_up : w_dn)
                          : ((w_dn != 2'd0) ? w_dn : w_up);
  assign new_dir = valid ? (target > cur_floor) : dir_up;

endmodule

// File: rtl/lift_scheduler.sv
// Call latch, SCAN sequencer and door/travel timers for the 3-floor lift.
// state  | meaning
// IDLE   | waiting for a pending call
// ISSUE  | dstn pulse to the lift (one cycle)
// TRAVEL | waiting for at_floor to match the target, timeout running
// DOOR   | door interval at the target floor
// FAULT  | travel timeout, held until reset
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int DOOR_CYCLES = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] req,
  input  logic [NFLOORS-1:0] at_floor,
  output logic [NFLOORS-1:0] dstn,
  output logic               door_open,
  output logic [NFLOORS-1:0] pending,
  output logic               dir_up,
  output logic               busy,
  output logic               fault
);

  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_cur_floor, r_target, w_door_floor, w_sel_target, w_at_idx;
  logic               r_dir_up, w_sel_valid, w_sel_dir, w_here, w_arrived;
  logic [NFLOORS-1:0] r_pending, r_dstn, w_clr_mask;
  logic [DW-1:0]      r_door_cnt;
  logic [TW-1:0]      r_timer;

  lift_next_floor u_next (
    .pending   (r_pending),
    .cur_floor (r_cur_floor),
    .dir_up    (r_dir_up),
    .target    (w_sel_target),
    .valid     (w_sel_valid),
    .new_dir   (w_sel_dir)
  );

  assign w_at_idx  = onehot_to_floor(at_floor);
  assign w_here    = |(r_pending & floor_to_onehot(r_cur_floor));
  assign w_arrived = (at_floor == floor_to_onehot(r_target));

  always_comb begin
    w_state_nxt  = r_state;
    w_door_floor = r_target;
    case (r_state)
      IDLE: begin
        if (w_here) begin
          w_state_nxt  = DOOR;
          w_door_floor = r_cur_floor;
        end else if (w_sel_valid) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:  w_state_nxt = TRAVEL;
      TRAVEL: begin
        if (w_arrived)                         w_state_nxt = DOOR;
        else if (r_timer == TW'(TIMEOUT - 1))  w_state_nxt = FAULT;
      end
      DOOR:   if (r_door_cnt == '0) w_state_nxt = IDLE;
      FAULT:  w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
    // Door floor call is masked from the entry edge to the last DOOR edge.
    w_clr_mask = '0;
    if (r_state == DOOR || w_state_nxt == DOOR) w_clr_mask = floor_to_onehot(w_door_floor);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_floor <= 2'd1;
      r_target    <= 2'd1;
      r_dir_up    <= 1'b1;
      r_pending   <= '0;
      r_dstn      <= '0;
      r_door_cnt  <= '0;
      r_timer     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_at_idx != 2'd0) r_cur_floor <= w_at_idx;
      if (r_state != FAULT) r_pending <= (r_pending | req) & ~w_clr_mask;
      r_dstn <= (w_state_nxt == ISSUE) ? floor_to_onehot(w_sel_target) : '0;
      if (r_state == IDLE) begin
        if (w_state_nxt == ISSUE) begin
          r_target <= w_sel_target;
          r_dir_up <= w_sel_dir;
        end else if (w_state_nxt == DOOR) begin
          r_target <= r_cur_floor;
        end
      end
      r_timer <= (r_state == TRAVEL) ? r_timer + 1'b1 : '0;
      if (w_state_nxt == DOOR && r_state != DOOR) r_door_cnt <= DW'(DOOR_CYCLES - 1);
      else if (r_door_cnt != '0)                  r_door_cnt <= r_door_cnt - 1'b1;
    end
  end

  assign dstn      = r_dstn;
  assign door_open = (r_state == DOOR);
  assign pending   = r_pending;
  assign dir_up    = r_dir_up;
  assign busy      = (r_state != IDLE);
  assign fault     = (r_state == FAULT);

endmodule

// File: tb/tb_lift_scheduler.sv
// Scoreboard bench for lift_scheduler: a SCAN service-order model feeds an
// event queue, a monitor pops on each dstn pulse / door opening.
module tb_lift_scheduler;

  localparam int DOOR_CYCLES = 3;
  localparam int TIMEOUT     = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] at_floor = 3'b001;
  logic [2:0] dstn, pending;
  logic       door_open, dir_up, busy, fault;

  always #5 clk = ~clk;

  lift_scheduler #(.DOOR_CYCLES(DOOR_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .at_floor  (at_floor),
    .dstn      (dstn),
    .door_open (door_open),
    .pending   (pending),
    .dir_up    (dir_up),
    .busy      (busy),
    .fault     (fault)
  );

  typedef struct {
    bit         is_door;
    int         floor;
    bit         dir;
    logic [2:0] pend;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cur = 1;
  bit   m_dir = 1'b1;
  bit   mon_en = 1'b0;
  bit   plant_en = 1'b0;

  function automatic logic [2:0] oh(input int f);
    return 3'(1 << (f - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dstn"},    32'(dstn),      32'h0);
    chk({pfx, "_door"},    32'(door_open), 32'h0);
    chk({pfx, "_pending"}, 32'(pending),   32'h0);
    chk({pfx, "_dir_up"},  32'(dir_up),    32'h1);
    chk({pfx, "_busy"},    32'(busy),      32'h0);
    chk({pfx, "_fault"},   32'(fault),     32'h0);
  endtask

  // Service order from idle for a batch of calls: current floor first,
  // then repeatedly the nearest call in the scan direction, reversing
  // only when nothing is left ahead.
  task automatic push_model(input logic [2:0] p);
    logic [2:0] s;
    int above, below, t;
    s = p;
    if (s[m_cur-1]) begin
      s[m_cur-1] = 1'b0;
      exp_q.push_back('{1'b1, m_cur, m_dir, s});
    end
    while (s != 3'b000) begin
      above = 0;
      below = 0;
      for (int f = 1; f <= 3; f++) begin
        if (s[f-1] && f > m_cur && above == 0) above = f;
        if (s[f-1] && f < m_cur) below = f;
      end
      if (m_dir) t = (above != 0) ? above : below;
      else       t = (below != 0) ? below : above;
      m_dir = (t > m_cur);
      exp_q.push_back('{1'b0, t, m_dir, s});
      s[t-1] = 1'b0;
      exp_q.push_back('{1'b1, t, m_dir, s});
      m_cur = t;
    end
  endtask

  // Monitor: compares every dstn pulse and door opening against the queue.
  initial begin
    ev_t e;
    bit  prev_door;
    int  door_len;
    prev_door = 1'b0;
    door_len  = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dstn != 3'b000) begin
          if (exp_q.size() == 0) begin
            chk("dstn_unexpected", 32'(dstn), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("dstn_kind", 32'(e.is_door), 32'h0);
            chk("dstn_target", 32'(dstn), 32'(oh(e.floor)));
            chk("dstn_dir_up", 32'(dir_up), 32'(e.dir));
          end
        end
        if (door_open && !prev_door) begin
          if (exp_q.size() == 0) begin
            chk("door_unexpected", 32'(door_open), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("door_kind", 32'(e.is_door), 32'h1);
            chk("door_floor", 32'(at_floor), 32'(oh(e.floor)));
            chk("door_pending", 32'(pending), 32'(e.pend));
          end
        end
        if (!door_open && prev_door) begin
          chk("door_len", 32'(door_len), 32'(DOOR_CYCLES));
          chk("door_then_idle", 32'(busy), 32'h0);
        end
        if (fault) chk("no_fault", 32'(fault), 32'h0);
      end
      door_len  = door_open ? (prev_door ? door_len + 1 : 1) : 0;
      prev_door = door_open;
    end
  end

  // Lift plant: leaves the floor, occasionally glitches multi-hot, then arrives.
  initial begin
    logic [2:0] tgt;
    int d;
    forever begin
      @(negedge clk);
      if (plant_en && dstn != 3'b000) begin
        tgt = dstn;
        d = $urandom_range(1, 6);
        at_floor = 3'b000;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          at_floor = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b000;
        end
        at_floor = tgt;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || door_open) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("idle_timeout", 32'(n), 32'h0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_batch(input logic [2:0] p, input bit absorb);
    bit first_door;
    int c0, ft;
    c0 = m_cur;
    first_door = p[c0-1];
    push_model(p);
    ft = exp_q[0].floor;
    @(negedge clk); req = p;
    @(negedge clk); req = 3'b000;
    @(negedge clk);
    if (first_door) chk("lat_door", 32'(door_open), 32'h1);
    else            chk("lat_dstn", 32'(dstn), 32'(oh(ft)));
    if (absorb && first_door) begin
      req = oh(c0);
      @(negedge clk); req = 3'b000;
    end
    wait_idle();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    plant_en = 1'b0;
    reset = 1'b1;
    req = 3'b000;
    at_floor = 3'b001;
    exp_q.delete();
    m_cur = 1;
    m_dir = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;
    plant_en = 1'b1;

    run_batch(3'b100, 1'b0);
    run_batch(3'b001, 1'b0);
    run_batch(3'b001, 1'b1);
    run_batch(3'b111, 1'b0);
    run_batch(3'b001, 1'b0);
    run_batch(3'b010, 1'b0);
    run_batch(3'b101, 1'b0);
    run_batch(3'b100, 1'b0);
    run_batch(3'b010, 1'b0);
    run_batch(3'b101, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_batch(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    end

    // Travel timeout with the lift stuck at floor1.
    do_reset();
    @(negedge clk); req = 3'b100;
    @(negedge clk); req = 3'b000;
    @(negedge clk);
    chk("to_issue", 32'(dstn), 32'h4);
    repeat (16) @(negedge clk);
    chk("to_fault_early", 32'(fault), 32'h0);
    @(negedge clk);
    chk("to_fault", 32'(fault), 32'h1);
    req = 3'b111;
    @(negedge clk); req = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_no_dstn", 32'(dstn), 32'h0);
    end
    chk("to_sticky", 32'(fault), 32'h1);
    chk("to_busy", 32'(busy), 32'h1);
    chk("to_door", 32'(door_open), 32'h0);
    chk("to_pending_frozen", 32'(pending), 32'h4);

    // Reset during TRAVEL; calls in the reset cycle are dropped.
    do_reset();
    @(negedge clk); req = 3'b100;
    @(negedge clk); req = 3'b000;
    @(negedge clk);
    chk("rt_issue", 32'(dstn), 32'h4);
    @(negedge clk);
    chk("rt_travel_busy", 32'(busy), 32'h1);
    reset = 1'b1; req = 3'b011;
    @(negedge clk); reset = 1'b0; req = 3'b000;
    chk_reset_vals("rt");
    repeat (3) @(negedge clk);
    chk("rt_drop_pending", 32'(pending), 32'h0);
    chk("rt_drop_busy", 32'(busy), 32'h0);
    mon_en = 1'b1;
    plant_en = 1'b1;
    run_batch(3'b010, 1'b0);

    // Reset during DOOR at floor3; cur_floor must return to 1.
    run_batch(3'b100, 1'b0);
    mon_en = 1'b0;
    plant_en = 1'b0;
    @(negedge clk); req = 3'b100;
    @(negedge clk); req = 3'b000;
    @(negedge clk);
    chk("rd_door", 32'(door_open), 32'h1);
    at_floor = 3'b000;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk_reset_vals("rd");
    exp_q.delete();
    m_cur = 1;
    m_dir = 1'b1;
    mon_en = 1'b1;
    plant_en = 1'b1;
    run_batch(3'b010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
